// File: rtl/muller_c_driver.sv
// Clocked 4-phase stimulus/checker for a Muller C-element: drives a/b with a
// programmable skew, synchronizes the element output and measures follow latency.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | outputs low, waiting for start
// LEAD_HI | lead input high, lag low, for SKEW cycles; output must hold low
// WAIT_HI | both inputs high, waiting for c_sync=1 within TIMEOUT
// LEAD_LO | lead input low, lag high, for SKEW cycles; output must hold high
// WAIT_LO | both inputs low, waiting for c_sync=0 within TIMEOUT
// FIN     | inputs low, done pulse, result valid
module muller_c_driver #(
   parameter int SYNC_STAGES = 2,
   parameter int SKEW        = 3,
   parameter int TIMEOUT     = 16,
   parameter int ITER_W      = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start,
   input  logic [ITER_W-1:0] iters,
   input  logic              b_first,
   input  logic              c_in,
   output logic              a_out,
   output logic              b_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        err_code,
   output logic [7:0]        max_lat
);

   typedef enum logic [2:0] {
      IDLE, LEAD_HI, WAIT_HI, LEAD_LO, WAIT_LO, FIN
   } state_t;

   state_t              state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                c_sync;
   logic                lead_b;
   logic [ITER_W-1:0]   iter_rem;
   logic [7:0]          skew_cnt;
   logic [7:0]          lat_cnt;
   logic [7:0]          lat_val;
   logic [7:0]          lat_next;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], c_in};
   end

   assign c_sync = sync_q[SYNC_STAGES-1];

   // The counter is 1 during the first wait cycle, so the cycle in which the
   // synchronized output is first seen reports one less than the counter.
   assign lat_val  = lat_cnt - 8'd1;
   assign lat_next = (lat_cnt == 8'hFF) ? lat_cnt : lat_cnt + 8'd1;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         a_out    <= 1'b0;
         b_out    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         err_code <= 2'd0;
         max_lat  <= 8'd0;
         lead_b   <= 1'b0;
         iter_rem <= '0;
         skew_cnt <= 8'd0;
         lat_cnt  <= 8'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               a_out <= 1'b0;
               b_out <= 1'b0;
               if (start) begin
                  busy    <= 1'b1;
                  pass    <= 1'b0;
                  max_lat <= 8'd0;
                  if (c_sync) begin
                     fail     <= 1'b1;
                     err_code <= 2'd3;
                     done     <= 1'b1;
                     state    <= FIN;
                  end else begin
                     fail     <= 1'b0;
                     err_code <= 2'd0;
                     lead_b   <= b_first;
                     iter_rem <= (iters == '0) ? ITER_W'(1) : iters;
                     a_out    <= ~b_first;
                     b_out    <= b_first;
                     skew_cnt <= 8'(SKEW - 1);
                     state    <= LEAD_HI;
                  end
               end
            end
            LEAD_HI: begin
               if (c_sync) begin
                  a_out    <= 1'b0;
                  b_out    <= 1'b0;
                  fail     <= 1'b1;
                  err_code <= 2'd1;
                  done     <= 1'b1;
                  state    <= FIN;
               end else if (skew_cnt == 8'd0) begin
                  a_out   <= 1'b1;
                  b_out   <= 1'b1;
                  lat_cnt <= 8'd1;
                  state   <= WAIT_HI;
               end else begin
                  skew_cnt <= skew_cnt - 8'd1;
               end
            end
            WAIT_HI: begin
               if (c_sync) begin
                  if (lat_val > max_lat) max_lat <= lat_val;
                  a_out    <= lead_b;
                  b_out    <= ~lead_b;
                  skew_cnt <= 8'(SKEW - 1);
                  state    <= LEAD_LO;
               end else if (lat_cnt == 8'(TIMEOUT)) begin
                  a_out    <= 1'b0;
                  b_out    <= 1'b0;
                  fail     <= 1'b1;
                  err_code <= 2'd2;
                  done     <= 1'b1;
                  state    <= FIN;
               end else begin
                  lat_cnt <= lat_next;
               end
            end
            LEAD_LO: begin
               if (!c_sync) begin
                  a_out    <= 1'b0;
                  b_out    <= 1'b0;
                  fail     <= 1'b1;
                  err_code <= 2'd1;
                  done     <= 1'b1;
                  state    <= FIN;
               end else if (skew_cnt == 8'd0) begin
                  a_out   <= 1'b0;
                  b_out   <= 1'b0;
                  lat_cnt <= 8'd1;
                  state   <= WAIT_LO;
               end else begin
                  skew_cnt <= skew_cnt - 8'd1;
               end
            end
            WAIT_LO: begin
               if (!c_sync) begin
                  if (lat_val > max_lat) max_lat <= lat_val;
                  if (iter_rem == ITER_W'(1)) begin
                     pass  <= 1'b1;
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     iter_rem <= iter_rem - ITER_W'(1);
                     a_out    <= ~lead_b;
                     b_out    <= lead_b;
                     skew_cnt <= 8'(SKEW - 1);
                     state    <= LEAD_HI;
                  end
               end else if (lat_cnt == 8'(TIMEOUT)) begin
                  fail     <= 1'b1;
                  err_code <= 2'd2;
                  done     <= 1'b1;
                  state    <= FIN;
               end else begin
                  lat_cnt <= lat_next;
               end
            end
            FIN: begin
               a_out <= 1'b0;
               b_out <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/muller_c_driver.md
# muller_c_driver

Clocked 4-phase stimulus and checker that sits directly upstream of the Muller C-element project. It drives the element's two inputs through repeated full handshake cycles, using a programmable skew between the two input edges. It synchronizes the element's output back into the clock domain and checks three things:
- the output holds while only one input has changed;
- the output follows within a bounded time once both inputs agree;
- the worst observed latency, which it reports.

It feeds the C-element's input pins and consumes its output pin, and presents a simple start/done status interface to the management side.

## Interface
Parameters:
- SYNC_STAGES, 2: flops in the synchronizer on c_in (minimum 2).
- SKEW, 3: cycles the first input leads the second, on both edges (1..255).
- TIMEOUT, 16: maximum cycles to wait for c_sync to follow once both inputs agree (1..255).
- ITER_W, 8: width of the iteration count.

Ports:
- wb_clk_i, input, 1: clock.
- wb_rst_i, input, 1: reset; asynchronous, active-high.
- start, input, 1: begin a run; sampled only in IDLE.
- iters, input, ITER_W: number of full handshakes per run; 0 is treated as 1. Latched on start.
- b_first, input, 1: 1 means b leads a on both edges. Latched on start.
- c_in, input, 1: asynchronous C-element output.
- a_out, input-side drive, output, 1: C-element input a, registered.
- b_out, output, 1: C-element input b, registered.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at the end of a run (pass or fail).
- pass, output, 1: sticky result; cleared on start.
- fail, output, 1: sticky result; cleared on start.
- err_code, output, 2: 0 none, 1 premature output change, 2 timeout, 3 output not low at start.
- max_lat, output, 8: largest follow latency in cycles seen this run; cleared on start.

## Operation
- c_sync is c_in delayed through SYNC_STAGES flops, reset to 0. All checks use c_sync.
- "Lead" means a if b_first=0, otherwise b. "Lag" is the other input.
- FSM states: IDLE, LEAD_HI, WAIT_HI, LEAD_LO, WAIT_LO, FIN.
- IDLE: a_out=b_out=0.
  - start=1 and c_sync=0: latch iters/b_first, clear pass/fail/err_code/max_lat, go to LEAD_HI.
  - start=1 and c_sync=1: fail=1, err_code=3, go to FIN.
- LEAD_HI: lead=1, lag=0 for SKEW cycles.
  - c_sync=1 at any point: fail, err_code=1, go to FIN.
  - Otherwise go to WAIT_HI.
- WAIT_HI: both inputs 1; the latency counter runs from 1.
  - c_sync=1: update max_lat = max(max_lat, counter), go to LEAD_LO.
  - Counter reaches TIMEOUT with c_sync=0: fail, err_code=2, go to FIN.
- LEAD_LO: lead=0, lag=1 for SKEW cycles.
  - c_sync=0 at any point: err_code=1, go to FIN.
  - Otherwise go to WAIT_LO.
- WAIT_LO: both inputs 0; same latency and timeout rules, waiting for c_sync=0.
  - On success, decrement the remaining-iteration count.
  - Count was 1: pass=1, go to FIN.
  - Otherwise go to LEAD_HI.
- FIN: a_out=b_out=0, done=1 for one cycle, then go to IDLE. start is ignored in FIN.
- Any fail drives both inputs to 0 on the next edge.
- max_lat saturates at 255.
- The latency counter saturates and never wraps.

## Timing
- Reset values (asynchronous, take effect immediately):
  - FSM = IDLE.
  - a_out, b_out, busy, done, pass, fail = 0.
  - err_code = 0, max_lat = 0.
  - Synchronizer flops = 0, counters = 0.
- Reset asserted mid-run drops a_out/b_out at once, with no done pulse. After deassertion the block is idle and waits for start.
- The lead input rises on the edge after start is sampled. The lag input rises exactly SKEW cycles later, and falling edges are spaced the same way.
- Reported latency includes the SYNC_STAGES synchronizer delay. With an ideal zero-delay C-element and SYNC_STAGES=2, latency = 2.
- busy rises on the edge after start and falls on the edge after FIN.
- done and the final pass/fail/err_code become valid in the same cycle. pass/fail hold until the next accepted start or reset.
- A start held high across FIN starts a new run in the first cycle back in IDLE.

## Test plan
- Basic run: ideal C-element model with 0-cycle delay, SKEW=3, iters=4, b_first=0. Expect:
  - a leads b by 3 cycles on every edge;
  - done after 4 handshakes, pass=1, max_lat=2, err_code=0.
- Delay and swapped order: model delay 5 cycles, b_first=1. Expect b leading, max_lat=7, pass.
- Premature change: replace the model with an OR gate. Expect c rising during LEAD_HI, fail=1, err_code=1, a_out=b_out=0 the next cycle, done pulse.
- Timeout: c_in stuck at 0, TIMEOUT=16. Expect fail with err_code=2 exactly 16 cycles after WAIT_HI entry.
- Output not low at start: c_in=1 at start. Expect err_code=3, and neither a_out nor b_out ever asserted.
- Mid-run reset: assert wb_rst_i in WAIT_HI. Expect all outputs 0 immediately; after release, iters=1 completes with pass.
